// File: rtl/uart_pkg.sv
// Shared UART receive definitions: parity encodings, frame FSM states and
// the prescale/bit-timer widths.
package uart_pkg;

    localparam int PRESCALE_W = 16;
    localparam int BITCNT_W   = PRESCALE_W + 3;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_RSVD = 2'b11
    } parity_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK_WAIT
    } rx_state_e;

    // The reserved encoding behaves like "no parity".
    function automatic logic parity_en(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_ext_if.sv
// Stream handshake carrying received characters out of the UART.
interface uart_rx_ext_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO; a push into a full FIFO is dropped even if a pop
// happens in the same cycle.
module uart_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [DATA_WIDTH-1:0]        push_data,
    input  logic                         pop,
    output logic [DATA_WIDTH-1:0]        head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(FIFO_DEPTH):0]  count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  do_push, do_pop;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = count_q;
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/uart_rx_ext.sv
// UART receiver: synchronized line, frame FSM with optional parity and one or
// two stop bits, break detection, and a receive FIFO on a stream port.
module uart_rx_ext
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rxd,
    input  logic [PRESCALE_W-1:0]        prescale,
    input  logic [1:0]                   parity_mode,
    input  logic                         stop_bits,
    uart_rx_ext_if.master                m_axis,
    output logic                         rx_busy,
    output logic                         rx_frame_error,
    output logic                         rx_parity_error,
    output logic                         rx_overrun_error,
    output logic                         rx_break,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
    logic                  sync1_q, sync2_q, prev_q;
    rx_state_e             state_q, state_d;
    logic [BITCNT_W-1:0]   cnt_q, cnt_d, period_m1;
    logic [3:0]            bit_q, bit_d;
    logic [DATA_WIDTH-1:0] data_q, data_d, fifo_head;
    logic                  par_bit_q, par_bit_d, stop_ok_q, stop_ok_d;
    logic [PRESCALE_W-1:0] pre_q, pre_d, eff_pre;
    logic [1:0]            pmode_q, pmode_d;
    logic                  stop2_q, stop2_d;
    logic                  push_q, push_d, frame_err_q, frame_err_d;
    logic                  par_err_q, par_err_d, break_q, break_d;
    logic                  rxd_s, fall, tick, stop_now, par_on, par_bad, all_zero;
    logic                  fifo_full, fifo_empty, fifo_pop;

    assign rxd_s     = sync2_q;
    assign fall      = prev_q & ~sync2_q;
    assign eff_pre   = (prescale == '0) ? PRESCALE_W'(1) : prescale;
    assign period_m1 = {pre_q, 3'b000} - BITCNT_W'(1);
    assign tick      = (cnt_q == '0);
    assign stop_now  = stop_ok_q & rxd_s;
    assign par_on    = parity_en(pmode_q);
    assign par_bad   = ((^data_q) ^ par_bit_q) != (pmode_q == PAR_ODD);
    // A break is an all-zero character including any parity bit.
    assign all_zero  = (data_q == '0) && !(par_on && par_bit_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = tick ? cnt_q : cnt_q - BITCNT_W'(1);
        bit_d       = bit_q;
        data_d      = data_q;
        par_bit_d   = par_bit_q;
        stop_ok_d   = stop_ok_q;
        pre_d       = pre_q;
        pmode_d     = pmode_q;
        stop2_d     = stop2_q;
        push_d      = 1'b0;
        frame_err_d = 1'b0;
        par_err_d   = 1'b0;
        break_d     = 1'b0;
        case (state_q)
            ST_IDLE: if (fall) begin
                state_d   = ST_START;
                pre_d     = eff_pre;
                pmode_d   = parity_mode;
                stop2_d   = stop_bits;
                cnt_d     = {1'b0, eff_pre, 2'b00} - BITCNT_W'(1);
                bit_d     = '0;
                par_bit_d = 1'b0;
                stop_ok_d = 1'b1;
            end
            ST_START: if (tick) begin
                state_d = rxd_s ? ST_IDLE : ST_DATA;
                cnt_d   = period_m1;
            end
            ST_DATA: if (tick) begin
                data_d = {rxd_s, data_q[DATA_WIDTH-1:1]};
                cnt_d  = period_m1;
                bit_d  = bit_q + 4'd1;
                if (bit_q == 4'(DATA_WIDTH - 1)) begin
                    bit_d   = '0;
                    state_d = par_on ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: if (tick) begin
                par_bit_d = rxd_s;
                cnt_d     = period_m1;
                state_d   = ST_STOP;
            end
            ST_STOP: if (tick) begin
                stop_ok_d = stop_now;
                if (stop2_q && (bit_q == '0)) begin
                    bit_d = 4'd1;
                    cnt_d = period_m1;
                end else if (!stop_now && all_zero) begin
                    break_d = 1'b1;
                    state_d = ST_BREAK_WAIT;
                end else begin
                    state_d     = ST_IDLE;
                    frame_err_d = !stop_now;
                    par_err_d   = stop_now && par_on && par_bad;
                    push_d      = stop_now && !(par_on && par_bad);
                end
            end
            ST_BREAK_WAIT: if (rxd_s) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            data_q      <= '0;
            par_bit_q   <= 1'b0;
            stop_ok_q   <= 1'b1;
            pre_q       <= PRESCALE_W'(1);
            pmode_q     <= PAR_NONE;
            stop2_q     <= 1'b0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            par_err_q   <= 1'b0;
            break_q     <= 1'b0;
        end else begin
            sync1_q     <= rxd;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            data_q      <= data_d;
            par_bit_q   <= par_bit_d;
            stop_ok_q   <= stop_ok_d;
            pre_q       <= pre_d;
            pmode_q     <= pmode_d;
            stop2_q     <= stop2_d;
            push_q      <= push_d;
            frame_err_q <= frame_err_d;
            par_err_q   <= par_err_d;
            break_q     <= break_d;
        end
    end

    assign fifo_pop = m_axis.tvalid & m_axis.tready;

    uart_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_q),
        .push_data (data_q),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign m_axis.tdata     = fifo_head;
    assign m_axis.tvalid    = ~fifo_empty;
    assign rx_busy          = (state_q != ST_IDLE);
    assign rx_frame_error   = frame_err_q;
    assign rx_parity_error  = par_err_q;
    assign rx_break         = break_q;
    assign rx_overrun_error = push_q & fifo_full;

endmodule

// File: doc/uart_rx_ext.md
UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 Parameter DATA_WIDTH, default 8: data bits per frame, legal 5..9.
REQ-002 Parameter FIFO_DEPTH, default 16: receive FIFO entries, power of two, >=2.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rxd  input  1  serial line, idle high, asynchronous to clk.
REQ-006 prescale  input  16  bit period = prescale*8 clk cycles; 0 treated as 1.
REQ-007 parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none.
REQ-008 stop_bits  input  1  0 = one stop bit, 1 = two stop bits.
REQ-009 m_axis_tdata  output  DATA_WIDTH  FIFO head byte.
REQ-010 m_axis_tvalid  output  1  FIFO non-empty.
REQ-011 m_axis_tready  input  1  consumer accept.
REQ-012 rx_busy  output  1  high in any state other than IDLE.
REQ-013 rx_frame_error, rx_parity_error, rx_overrun_error, rx_break  output  1 each  one-cycle pulses.
REQ-014 fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.

Function
REQ-015 rxd passes through a 2-flop synchronizer; all line decisions use the synchronized value.
REQ-016 FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
REQ-017 IDLE->START on synchronized falling edge; prescale, parity_mode, stop_bits latched at this point and held for the whole frame.
REQ-018 START samples line after prescale*4 cycles; low -> DATA, high -> IDLE with no error (glitch rejection).
REQ-019 DATA samples each bit at mid-bit, every prescale*8 cycles, LSB first, DATA_WIDTH bits.
REQ-020 PARITY is entered only when parity enabled; even: XOR(data, parity bit) must be 0; odd: must be 1.
REQ-021 STOP samples one or two stop bits at mid-bit; every sampled stop bit must be high.
REQ-022 Good frame (stop high, parity OK): push data into FIFO in the cycle after the last stop sample; m_axis_tvalid high the following cycle if FIFO was empty; FSM -> IDLE same cycle as push.
REQ-023 Any stop bit low with data and parity bits all zero: rx_break pulse, no push, -> BREAK_WAIT; leave to IDLE only after line sampled high.
REQ-024 Other stop bit low: rx_frame_error pulse, byte discarded, -> IDLE.
REQ-025 Parity mismatch with valid stop: rx_parity_error pulse, byte discarded; frame error takes priority if both occur.
REQ-026 Good frame while FIFO full: rx_overrun_error pulse, new byte dropped, FIFO contents unchanged.
REQ-027 Pop when m_axis_tvalid && m_axis_tready; m_axis_tdata shows the next entry the following cycle.
REQ-028 Simultaneous push and pop: fullness checked before pop, so push into full FIFO is overrun even with concurrent pop; otherwise both happen and fifo_count unchanged.
REQ-029 Pointers wrap modulo FIFO_DEPTH; fifo_count never exceeds FIFO_DEPTH nor underflows.
REQ-030 Config input changes mid-frame have no effect until the next start bit.

Reset
REQ-031 On rst: FSM IDLE, synchronizer flops 1, FIFO empty, fifo_count 0, m_axis_tvalid 0, m_axis_tdata 0, rx_busy 0, all error/break pulses 0.
REQ-032 rst asserted mid-frame aborts the frame with no push and no error pulse; first frame accepted is the first falling edge after rst deasserts.

Structure
REQ-033 Shared package uart_pkg holds parity_mode encodings, the FSM state enum and the prescale width constant.
REQ-034 FIFO is a sub-module uart_fifo (sync FIFO, DATA_WIDTH x FIFO_DEPTH, push/pop/full/empty/count).

Verification (prescale=1, 8 clk per bit)
REQ-035 8N1, bytes 0x00,0x55,0xA5,0xFF sent, tready=1 -> same four bytes on m_axis in order, no error pulses.
REQ-036 DATA_WIDTH=7, odd parity, 2 stop, 0x41 with correct parity then 0x41 with flipped parity -> first delivered, second rx_parity_error pulse, fifo_count stays 0 after pop.
REQ-037 8N1, 0x3C with stop bit driven low -> rx_frame_error one pulse, nothing pushed; 0x00 with line held low 20 bit times -> single rx_break, no push, next 0x12 received correctly.
REQ-038 FIFO_DEPTH=4, tready=0, send 0x01..0x05 -> fifo_count 4, rx_overrun_error on fifth, then draining yields 0x01..0x04.
REQ-039 rxd low pulse of 2 clk in IDLE -> returns IDLE, no push, no error; rst asserted mid-byte -> fifo_count 0, all outputs at reset values.
